// File: rtl/q14_pkg.sv
// Shared types and sizing for the sequential right shifter.
package q14_pkg;

   localparam int unsigned WIDTH = 8;
   localparam int unsigned IDX_W = $clog2(WIDTH);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      FIN   = 2'd2
   } state_t;

endpackage

// File: rtl/q14_onehot_enc.sv
// One-hot to binary encoder; valid_c only when exactly one bit is set.
module q14_onehot_enc
   import q14_pkg::*;
#(
   parameter int unsigned WIDTH = q14_pkg::WIDTH,
   parameter int unsigned IDX_W = $clog2(WIDTH)
) (
   input  logic [WIDTH-1:0] onehot,
   output logic [IDX_W-1:0] idx_c,
   output logic             valid_c
);

   localparam int unsigned CNT_W = $clog2(WIDTH + 1);

   logic [CNT_W-1:0] ones;

   // OR of set-bit indices is only meaningful when exactly one bit is set
   always_comb begin
      ones  = '0;
      idx_c = '0;
      for (int i = 0; i < int'(WIDTH); i++) begin
         if (onehot[i]) begin
            ones  = ones + CNT_W'(1);
            idx_c = idx_c | IDX_W'(i);
         end
      end
      valid_c = (ones == CNT_W'(1));
   end

endmodule

// File: rtl/q14_seq_right_shifter.sv
// Iterative logical right shifter: one bit per clock, one-hot amount,
// done/err pulse when the result register W is updated.
module q14_seq_right_shifter
   import q14_pkg::*;
#(
   parameter int unsigned WIDTH = q14_pkg::WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] D,
   input  logic [WIDTH-1:0] N,
   output logic [WIDTH-1:0] W,
   output logic             busy,
   output logic             done,
   output logic             err
);

   localparam int unsigned CNT_W = $clog2(WIDTH);

   state_t           state, state_nxt;
   logic [WIDTH-1:0] data, data_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             eflag, eflag_nxt;
   logic [WIDTH-1:0] w_nxt;
   logic             busy_nxt, done_nxt, err_nxt;
   logic [CNT_W-1:0] enc_idx;
   logic             enc_valid;

   q14_onehot_enc #(
      .WIDTH (WIDTH),
      .IDX_W (CNT_W)
   ) u_enc (
      .onehot  (N),
      .idx_c   (enc_idx),
      .valid_c (enc_valid)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         data  <= '0;
         cnt   <= '0;
         eflag <= 1'b0;
         W     <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
         err   <= 1'b0;
      end else begin
         state <= state_nxt;
         data  <= data_nxt;
         cnt   <= cnt_nxt;
         eflag <= eflag_nxt;
         W     <= w_nxt;
         busy  <= busy_nxt;
         done  <= done_nxt;
         err   <= err_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      data_nxt  = data;
      cnt_nxt   = cnt;
      eflag_nxt = eflag;
      w_nxt     = W;
      done_nxt  = 1'b0;
      err_nxt   = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) begin
               if (enc_valid) begin
                  data_nxt  = D;
                  cnt_nxt   = enc_idx;
                  state_nxt = (enc_idx == '0) ? FIN : SHIFT;
               end else begin
                  // Malformed amount: zero result, flagged, no shifting
                  data_nxt  = '0;
                  cnt_nxt   = '0;
                  eflag_nxt = 1'b1;
                  state_nxt = FIN;
               end
            end
         end
         SHIFT: begin
            data_nxt = {1'b0, data[WIDTH-1:1]};
            cnt_nxt  = cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) state_nxt = FIN;
         end
         FIN: begin
            w_nxt     = data;
            done_nxt  = 1'b1;
            err_nxt   = eflag;
            eflag_nxt = 1'b0;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      busy_nxt = (state_nxt != IDLE);
   end

endmodule

// File: tb/tb_q14_seq_right_shifter.sv
// Scoreboard bench: stimulus pushes expected results, a monitor checks each done.
module tb_q14_seq_right_shifter;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic [7:0] D, N, W;
   logic       busy, done, err;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   typedef struct {
      logic [7:0] w;
      logic       e;
      int         cyc;
   } exp_t;

   exp_t sb[$];

   q14_seq_right_shifter dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .D     (D),
      .N     (N),
      .W     (W),
      .busy  (busy),
      .done  (done),
      .err   (err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every done must match the oldest outstanding expectation
   always @(negedge clk) begin
      if (rst_n && done) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: W=%0h err=%0b with no pending request", W, err);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("result_W", int'(W), int'(e.w));
            chk("result_err", int'(err), int'(e.e));
            chk("done_cycle", cyc, e.cyc);
         end
      end
   end

   // Called just after a rising edge; the next edge accepts the request
   task automatic issue(input logic [7:0] d, input logic [7:0] n,
                        input logic [7:0] w, input logic e, input int lat);
      exp_t x;
      start = 1'b1;
      D     = d;
      N     = n;
      x.w   = w;
      x.e   = e;
      x.cyc = cyc + 1 + lat;
      sb.push_back(x);
      @(posedge clk); #1;
      start = 1'b0;
      D     = 8'h5A;
      N     = 8'h3C;
   endtask

   task automatic wait_idle(input string name, input int lat);
      int n = 0;
      while (busy && n < 20) begin
         n++;
         @(posedge clk); #1;
      end
      chk(name, n, lat);
   endtask

   function automatic logic [7:0] shl(input logic [7:0] d, input logic [7:0] n);
      logic [7:0] r = d;
      for (int i = 0; i < 8; i++) if (n[i]) r = d << i;
      return r;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] rt;
      rst_n = 1'b0;
      start = 1'b0;
      D     = 8'h00;
      N     = 8'h00;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_W", int'(W), 0);
      chk("reset_busy", int'(busy), 0);
      chk("reset_done", int'(done), 0);
      chk("reset_err", int'(err), 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      issue(8'hB4, 8'h01, 8'hB4, 1'b0, 1);
      wait_idle("busy_n01", 1);
      @(posedge clk); #1;

      issue(8'hB4, 8'h04, 8'h2D, 1'b0, 3);
      wait_idle("busy_n04", 3);
      @(posedge clk); #1;

      issue(8'hFF, 8'h80, 8'h01, 1'b0, 8);
      wait_idle("busy_n80", 8);
      @(posedge clk); #1;

      issue(8'hB4, 8'h06, 8'h00, 1'b1, 1);
      wait_idle("busy_n06", 1);
      @(posedge clk); #1;
      issue(8'hB4, 8'h00, 8'h00, 1'b1, 1);
      wait_idle("busy_n00", 1);
      @(posedge clk); #1;

      // Second start mid-SHIFT must be ignored
      issue(8'hB4, 8'h10, 8'h0B, 1'b0, 5);
      @(posedge clk); #1;
      start = 1'b1;
      D     = 8'hFF;
      N     = 8'h01;
      @(posedge clk); #1;
      start = 1'b0;
      wait_idle("busy_ignored_start", 3);
      @(posedge clk); #1;

      // Reset mid-SHIFT abandons the operation
      issue(8'hFF, 8'h80, 8'h01, 1'b0, 8);
      repeat (3) begin
         @(posedge clk); #1;
      end
      rst_n = 1'b0;
      void'(sb.pop_back());
      #1;
      chk("midrst_W", int'(W), 0);
      chk("midrst_busy", int'(busy), 0);
      chk("midrst_done", int'(done), 0);
      repeat (2) begin
         @(posedge clk); #1;
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
      issue(8'h81, 8'h02, 8'h40, 1'b0, 2);
      wait_idle("busy_after_rst", 2);
      @(posedge clk); #1;

      // Round trip through a left shift, then a start in the done cycle
      rt = shl(8'h0F, 8'h08);
      issue(rt, 8'h08, 8'h0F, 1'b0, 4);
      repeat (4) begin
         @(posedge clk); #1;
      end
      chk("b2b_done_high", int'(done), 1);
      issue(8'hC3, 8'h02, 8'h61, 1'b0, 2);
      wait_idle("busy_b2b", 2);

      repeat (4) begin
         @(posedge clk); #1;
      end
      chk("scoreboard_empty", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
